// File: rtl/uart_rx_framed_if.sv
// ---------------------------------------------------------------------------
// uart_rx_framed_if
//   Bundles the serial line and the received-byte outputs of uart_rx_framed.
//
//   Signals:
//     i_Rx_Serial     serial line into the receiver (idle high)
//     o_Rx_DV         one-cycle pulse: o_Rx_Byte holds a new good byte
//     o_Rx_Byte [7:0] last good byte, held until the next good byte
//     o_Rx_Frame_Err  one-cycle pulse: stop bit sampled low
//     o_Rx_Break      level: frame error with all data bits zero
//     o_Rx_Active     high while a validated frame is being received
//
//   Modports:
//     slave  - the receiver (consumes the line, drives the outputs)
//     master - the line driver / byte consumer side
// ---------------------------------------------------------------------------
interface uart_rx_framed_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Break;
  logic       o_Rx_Active;

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Frame_Err,
    output o_Rx_Break,
    output o_Rx_Active
  );

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Frame_Err,
    input  o_Rx_Break,
    input  o_Rx_Active
  );
endinterface

// File: rtl/uart_rx_framed.sv
// ---------------------------------------------------------------------------
// uart_rx_framed
//   UART receiver: 1 start bit, 8 data bits (LSB first), 1 stop bit, no
//   parity. The asynchronous line is brought in through a 2-FF synchroniser;
//   the start bit is re-checked at its middle, each data bit and the stop bit
//   are sampled at mid-bit. Good bytes are presented with a one-cycle valid
//   pulse; bad stop bits raise a one-cycle frame-error pulse instead, and a
//   frame error on an all-zero byte also raises the break level.
//
//   Parameters:
//     CLKS_PER_BIT  clocks per bit period (4..65535)
//
//   Ports:
//     i_Clock       system clock, rising edge
//     i_Rst_n       asynchronous active-low reset
//     rx_if         uart_rx_framed_if.slave (line in, byte/status out)
//
//   Build option:
//     UART_RX_MAJORITY_EN  when defined, every sample point uses a 2-of-3
//                          vote over the current and two previous
//                          synchronised line values; timing is unchanged.
// ---------------------------------------------------------------------------
module uart_rx_framed #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  uart_rx_framed_if.slave  rx_if
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_CLEANUP = 3'd4;

  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  // -------------------------------------------------------------------------
  // Input synchroniser (reset to the idle level so reset never looks like a
  // start bit)
  // -------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_if.i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // Value used at each sample point
  // -------------------------------------------------------------------------
  logic sample_bit;

`ifdef UART_RX_MAJORITY_EN
  // Together with the current rx_s this forms a 3-deep history window; a
  // single-cycle glitch on any one of the three is outvoted.
  logic [1:0] hist_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign sample_bit = (rx_s_q & hist_q[0]) |
                      (rx_s_q & hist_q[1]) |
                      (hist_q[0] & hist_q[1]);
`else
  assign sample_bit = rx_s_q;
`endif

  // -------------------------------------------------------------------------
  // Receive state machine
  // -------------------------------------------------------------------------
  logic [2:0]  state_q,  state_d;
  logic [15:0] cnt_q,    cnt_d;
  logic [2:0]  bit_q,    bit_d;
  logic [7:0]  shift_q,  shift_d;
  logic [7:0]  byte_q,   byte_d;
  logic        dv_q,     dv_d;
  logic        ferr_q,   ferr_d;
  logic        brk_q,    brk_d;
  logic        active_q, active_d;
  logic        armed_q,  armed_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    brk_d    = brk_q;
    active_d = active_q;
    armed_d  = armed_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_s_q) begin
          // A high line both arms start detection and ends a break.
          armed_d = 1'b1;
          brk_d   = 1'b0;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!sample_bit) begin
            state_d  = S_DATA;
            active_d = 1'b1;
          end else begin
            // Line went back high before mid-bit: treat as noise.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = sample_bit;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_CLEANUP;
          if (sample_bit) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            // The line is already high at the stop sample, so a start edge
            // arriving in CLEANUP or the first IDLE cycle is still accepted.
            armed_d = 1'b1;
          end else begin
            // Not armed here: a line stuck low must go high in IDLE before
            // another start is considered.
            ferr_d = 1'b1;
            if (shift_q == 8'h00) begin
              brk_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_CLEANUP: begin
        active_d = 1'b0;
        state_d  = S_IDLE;
        if (rx_s_q) begin
          armed_d = 1'b1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        bit_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      byte_q   <= 8'h00;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      active_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      brk_q    <= brk_d;
      active_q <= active_d;
      armed_q  <= armed_d;
    end
  end

  assign rx_if.o_Rx_DV        = dv_q;
  assign rx_if.o_Rx_Byte      = byte_q;
  assign rx_if.o_Rx_Frame_Err = ferr_q;
  assign rx_if.o_Rx_Break     = brk_q;
  assign rx_if.o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_framed
//   Drives UART frames into uart_rx_framed (CLKS_PER_BIT = 8). Every frame
//   sent pushes its expected outcome (good byte, or frame error with/without
//   break) into a scoreboard queue; an independent monitor pops an entry for
//   each DV or frame-error pulse the receiver presents.
// ---------------------------------------------------------------------------
module tb_uart_rx_framed;
  localparam int CPB = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_framed_if rx_if ();

  uart_rx_framed #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .rx_if   (rx_if)
  );

  typedef struct packed {
    logic       is_err;
    logic       brk;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp     = 0;
  int         n_bad     = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what a receiver sees for a frame. With a glitch at
  // every data mid-point, a single-sample receiver reads each data bit
  // inverted; a voting receiver reads the transmitted byte.
  task automatic expect_frame(input logic [7:0] b, input logic stop, input logic glitch);
    exp_t       e;
    logic [7:0] seen;
    seen = b;
`ifndef UART_RX_MAJORITY_EN
    if (glitch) seen = ~b;
`endif
    e.is_err = !stop;
    e.brk    = !stop && (seen == 8'h00);
    e.data   = seen;
    sb_q.push_back(e);
    $display("frame: tx=0x%02h stop=%0d glitch=%0d -> expect %s 0x%02h",
             b, stop, glitch, stop ? "byte" : "frame-err", seen);
  endtask

  // Line driving: all changes happen 1 time unit after a rising edge.
  task automatic idle_bits(input int n);
    rx_if.i_Rx_Serial = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input logic glitch);
    for (int j = 0; j < CPB; j++) begin
      rx_if.i_Rx_Serial = (glitch && j == CPB / 2) ? ~v : v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic glitch);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], glitch);
    drive_bit(stop, 1'b0);
  endtask

  // Monitor: one scoreboard entry per output pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (rx_if.o_Rx_DV || rx_if.o_Rx_Frame_Err)) begin
      check("dv_ferr_overlap", rx_if.o_Rx_DV & rx_if.o_Rx_Frame_Err, 0);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {rx_if.o_Rx_DV, rx_if.o_Rx_Frame_Err}, 0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_kind_ferr", rx_if.o_Rx_Frame_Err, e.is_err);
        if (!e.is_err) begin
          check("rx_byte", rx_if.o_Rx_Byte, e.data);
          last_good = e.data;
          $display("rx: byte 0x%02h (expected 0x%02h)", rx_if.o_Rx_Byte, e.data);
        end else begin
          check("byte_hold_on_ferr", rx_if.o_Rx_Byte, last_good);
          check("break_at_ferr", rx_if.o_Rx_Break, e.brk);
          $display("rx: frame error break=%0d (expected %0d)", rx_if.o_Rx_Break, e.brk);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       act_seen;
    logic [7:0] rb;
    logic       rs;
    int         gap;

    rx_if.i_Rx_Serial = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset values and a quiet idle line.
    check("reset_dv",     rx_if.o_Rx_DV, 0);
    check("reset_byte",   rx_if.o_Rx_Byte, 8'h00);
    check("reset_ferr",   rx_if.o_Rx_Frame_Err, 0);
    check("reset_break",  rx_if.o_Rx_Break, 0);
    check("reset_active", rx_if.o_Rx_Active, 0);
    act_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      act_seen = act_seen | rx_if.o_Rx_Active;
    end
    check("idle_active", act_seen, 0);

    // Back-to-back good frames.
    expect_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    expect_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle_bits(2);

    // Short low glitch in IDLE is a false start.
    rx_if.i_Rx_Serial = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_if.i_Rx_Serial = 1'b1;
    act_seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      act_seen = act_seen | rx_if.o_Rx_Active;
    end
    check("glitch_active", act_seen, 0);
    expect_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle_bits(2);

    // Bad stop bit, then a long break, then a good frame.
    expect_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0);
    idle_bits(2);
    expect_frame(8'h00, 1'b0, 1'b0);
    rx_if.i_Rx_Serial = 1'b0;
    repeat (30 * CPB) @(posedge clk);
    #1;
    check("break_level", rx_if.o_Rx_Break, 1);
    check("break_not_active", rx_if.o_Rx_Active, 0);
    rx_if.i_Rx_Serial = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("break_cleared", rx_if.o_Rx_Break, 0);
    idle_bits(1);
    expect_frame(8'h42, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0);
    idle_bits(2);

    // Glitch at every data mid-point.
    expect_frame(8'hC3, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b1, 1'b1);
    idle_bits(2);

    // Randomised frames; a bad stop bit is always followed by idle time.
    for (int n = 0; n < 24; n++) begin
      rb  = 8'($urandom);
      if ($urandom_range(0, 5) == 0) rb = 8'h00;
      rs  = ($urandom_range(0, 3) != 0);
      gap = rs ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
      expect_frame(rb, rs, 1'b0);
      send_frame(rb, rs, 1'b0);
      if (gap > 0) idle_bits(gap);
    end
    idle_bits(2);
    // Make sure the held byte is non-zero before the reset test.
    expect_frame(8'h99, 1'b1, 1'b0);
    send_frame(8'h99, 1'b1, 1'b0);
    idle_bits(2);

    // Reset in the middle of data bit 4.
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h7E >> i), 1'b0);
    rx_if.i_Rx_Serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midframe_active", rx_if.o_Rx_Active, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_active", rx_if.o_Rx_Active, 0);
    check("midrst_byte",   rx_if.o_Rx_Byte, 8'h00);
    check("midrst_dv",     rx_if.o_Rx_DV, 0);
    check("midrst_ferr",   rx_if.o_Rx_Frame_Err, 0);
    last_good = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_bits(2);
    expect_frame(8'h7E, 1'b1, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle_bits(3);

    check("scoreboard_empty", sb_q.size(), 0);
    check("final_byte", rx_if.o_Rx_Byte, last_good);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
